// File: rtl/async_fifo_single_clk.sv
// Single-clock FIFO with registered read data, full/empty flags, level outputs and synchronous flush.
// Optional sticky overflow/underflow outputs are enabled by defining ASYNC_FIFO_ERR_FLAGS_EN.
module async_fifo_single_clk #(
    parameter int DEEPTH_BIT = 6,
    parameter int DEEPTH     = 32,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wclr,
    input  logic                  rclr,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [WIDTH-1:0]      dati,
    output logic                  full,
    output logic                  empty,
    output logic [WIDTH-1:0]      dato,
    output logic [DEEPTH_BIT-1:0] wlevel,
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    output logic [DEEPTH_BIT-1:0] rlevel,
    output logic                  overflow,
    output logic                  underflow
`else
    output logic [DEEPTH_BIT-1:0] rlevel
`endif
);

    localparam int ADDR_W = DEEPTH_BIT - 1;

    logic [WIDTH-1:0]      mem [DEEPTH];

    logic [DEEPTH_BIT-1:0] wptr_q, wptr_d;
    logic [DEEPTH_BIT-1:0] rptr_q, rptr_d;
    logic [DEEPTH_BIT-1:0] wlevel_q, rlevel_q, level_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic [WIDTH-1:0]      dato_q, dato_d;
    logic                  flush, do_wr, do_rd, mem_we;

    always_comb begin
        flush  = wclr | rclr;
        // Accept decisions use the registered (pre-edge) flags.
        do_wr  = wr_en && !full_q;
        do_rd  = rd_en && !empty_q;
        mem_we = do_wr && !flush;

        wptr_d = wptr_q;
        rptr_d = rptr_q;
        dato_d = dato_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            dato_d = '0;
        end else begin
            if (do_wr) wptr_d = wptr_q + 1'b1;
            if (do_rd) begin
                rptr_d = rptr_q + 1'b1;
                dato_d = mem[rptr_q[ADDR_W-1:0]];
            end
        end

        level_d = wptr_d - rptr_d;
        empty_d = (wptr_d == rptr_d);
        full_d  = (wptr_d[DEEPTH_BIT-1] != rptr_d[DEEPTH_BIT-1]) &&
                  (wptr_d[ADDR_W-1:0] == rptr_d[ADDR_W-1:0]);
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[wptr_q[ADDR_W-1:0]] <= dati;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            wlevel_q <= '0;
            rlevel_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            dato_q   <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            wlevel_q <= level_d;
            rlevel_q <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            dato_q   <= dato_d;
        end
    end

    assign full   = full_q;
    assign empty  = empty_q;
    assign dato   = dato_q;
    assign wlevel = wlevel_q;
    assign rlevel = rlevel_q;

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    always_comb begin
        ovf_d = ovf_q | (wr_en && full_q);
        udf_d = udf_q | (rd_en && empty_q);
        if (flush) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = udf_q;
`endif

endmodule

// File: tb/tb_async_fifo_single_clk.sv
// Randomized and directed bench for async_fifo_single_clk against a queue-based reference model.
module tb_async_fifo_single_clk;

    localparam int DB = 6;
    localparam int D  = 32;
    localparam int W  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          wclr = 1'b0, rclr = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [W-1:0]  dati = '0;
    logic          full, empty;
    logic [W-1:0]  dato;
    logic [DB-1:0] wlevel, rlevel;
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    logic          overflow, underflow;
`endif

    async_fifo_single_clk #(.DEEPTH_BIT(DB), .DEEPTH(D), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .wclr(wclr), .rclr(rclr),
        .wr_en(wr_en), .rd_en(rd_en), .dati(dati),
        .full(full), .empty(empty), .dato(dato),
        .wlevel(wlevel),
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        .rlevel(rlevel), .overflow(overflow), .underflow(underflow)
`else
        .rlevel(rlevel)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, flags derived from its size.
    logic [W-1:0] mq[$];
    logic [W-1:0] m_dato = '0;
    bit           m_ovf = 1'b0, m_udf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_dato = '0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else if (wclr || rclr) begin
            mq.delete();
            m_dato = '0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else begin
            automatic bit can_w = (mq.size() < D);
            automatic bit can_r = (mq.size() != 0);
            if (wr_en && !can_w) m_ovf = 1'b1;
            if (rd_en && !can_r) m_udf = 1'b1;
            if (rd_en && can_r) m_dato = mq.pop_front();
            if (wr_en && can_w) mq.push_back(dati);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_full",   32'(full),   32'(mq.size() == D));
            chk("m_empty",  32'(empty),  32'(mq.size() == 0));
            chk("m_dato",   32'(dato),   32'(m_dato));
            chk("m_wlevel", 32'(wlevel), 32'(mq.size()));
            chk("m_rlevel", 32'(rlevel), 32'(mq.size()));
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
            chk("m_ovf", 32'(overflow),  32'(m_ovf));
            chk("m_udf", 32'(underflow), 32'(m_udf));
`endif
        end
    end

    // Drive one cycle: inputs change just after negedge; returns just after the posedge.
    task automatic cyc(input logic we, input logic re, input logic wc, input logic rc,
                       input logic [W-1:0] d);
        @(negedge clk);
        #1;
        wr_en = we; rd_en = re; wclr = wc; rclr = rc; dati = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_empty"},  32'(empty),  32'd1);
        chk({tag, "_full"},   32'(full),   32'd0);
        chk({tag, "_wlevel"}, 32'(wlevel), 32'd0);
        chk({tag, "_rlevel"}, 32'(rlevel), 32'd0);
        chk({tag, "_dato"},   32'(dato),   32'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        wclr = 1'b1; rclr = 1'b1;
        #2;
        chk_reset_vals("rst");
        cmp_en = 1'b1;
        @(negedge clk); #1 rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        chk_reset_vals("clr");

        // Fill to full, then an extra write that must be dropped.
        for (int i = 0; i < D; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'(i + 1));
            chk("fill_lvl", 32'(wlevel), 32'(i + 1));
        end
        chk("fill_full", 32'(full), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
        chk("ovw_lvl", 32'(wlevel), 32'd32);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        chk("ovw_flag", 32'(overflow), 32'd1);
`endif

        // Drain; 0xFF must never appear.
        for (int i = 0; i < D; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            chk("drain_dato", 32'(dato), 32'(i + 1));
        end
        chk("drain_empty", 32'(empty), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("udr_dato", 32'(dato), 32'h20);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        chk("udr_flag", 32'(underflow), 32'd1);
`endif

        // Move pointers near the end so the following traffic crosses the wrap.
        for (int i = 0; i < 28; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
        for (int i = 0; i < 28; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'hA0 + i));
        chk("hold_lvl5", 32'(wlevel), 32'd5);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'hB0 + k));
            chk("rw_lvl", 32'(rlevel), 32'd5);
            chk("rw_dato", 32'(dato), (k < 5) ? 32'(8'hA0 + k) : 32'(8'hB0 + k - 5));
        end

        // Flush via each clear input at level 12 with a concurrent write.
        for (int s = 0; s < 2; s++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
            for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h40 + i));
            chk("pre_flush_lvl", 32'(wlevel), 32'd12);
            cyc(1'b1, 1'b0, (s == 0), (s == 1), 8'hEE);
            chk_reset_vals("flush");
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h55);
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            chk("post_flush_dato", 32'(dato), 32'h55);
            chk("post_flush_empty", 32'(empty), 32'd1);
        end

        // Asynchronous reset between edges at level 7.
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h60 + i));
        chk("pre_arst_lvl", 32'(wlevel), 32'd7);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        @(negedge clk); #1 rst_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h77);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h78);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("arst_first", 32'(dato), 32'h77);
        chk("arst_lvl", 32'(wlevel), 32'd1);

        // Randomized traffic with biased write/read mixes and rare flushes.
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 600; i++) begin
                automatic int unsigned wp = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
                automatic logic we = ($urandom_range(99) < wp);
                automatic logic re = ($urandom_range(99) < 100 - wp + ((ph == 3) ? 20 : 0));
                automatic logic wc = ($urandom_range(127) == 0);
                automatic logic rc = ($urandom_range(127) == 0);
                cyc(we, re, wc, rc, 8'($urandom));
            end
        end

        wr_en = 1'b0; rd_en = 1'b0; wclr = 1'b0; rclr = 1'b0;
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
